// File: rtl/chrono_pkg.sv
// Shared types and constants for the chrono display/alert datapath.
package chrono_pkg;

  localparam int DATA_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALERT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] REQ_TIMER = 2'd0;
  localparam logic [1:0] REQ_ALARM = 2'd1;
  localparam logic [1:0] REQ_CHIME = 2'd2;

  localparam logic [2:0] KEY_S1 = 3'd1;
  localparam logic [2:0] KEY_S2 = 3'd2;
  localparam logic [2:0] KEY_S3 = 3'd3;
  localparam logic [2:0] KEY_S4 = 3'd4;

  // Fixed priority: the lowest set request index wins (timer before alarm before chime).
  function automatic logic [1:0] first_req(input logic [2:0] req);
    if (req[0])      first_req = REQ_TIMER;
    else if (req[1]) first_req = REQ_ALARM;
    else             first_req = REQ_CHIME;
  endfunction

endpackage

// File: rtl/ms_down_counter.sv
// Loadable millisecond down-counter that saturates at zero.
// The owner loads (period - 1), so the period has elapsed on the tick seen while o_zero is high.
module ms_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down once per tick and hold at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/alert_arbiter.sv
// Arbitrates the display and buzzer between the mode logic and three alert requesters.
// Fixed priority with pre-emption, timed auto-dismiss, key capture while an alert is up,
// and a quiet holdoff after each alert.
module alert_arbiter #(
  parameter int DATA_W     = chrono_pkg::DATA_W,
  parameter int ALERT_MS   = 10000,
  parameter int BLINK_MS   = 500,
  parameter int HOLDOFF_MS = 200
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick_ms,
  input  logic [2:0]          i_key_val,
  input  logic [DATA_W-1:0]   i_mode_data,
  input  logic [2:0]          i_req,
  input  logic [3*DATA_W-1:0] i_req_data,
  output logic [DATA_W-1:0]   o_data,
  output logic [2:0]          o_key_val_mode,
  output logic                o_buz,
  output logic                o_busy,
  output logic [1:0]          o_grant_id,
  output logic [2:0]          o_ack
);

  import chrono_pkg::*;

  localparam logic [15:0] ALERT_LOAD = 16'(ALERT_MS - 1);
  localparam logic [15:0] BLINK_LOAD = 16'(BLINK_MS - 1);
  localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF_MS - 1);

  state_t      r_state;
  logic        r_busy;
  logic [1:0]  r_grant;
  logic        r_buz;
  logic [2:0]  r_ack;

  logic        w_keyHit;
  logic        w_anyReq;
  logic [1:0]  w_firstReq;
  logic        w_grantReq;
  logic        w_preempt;
  logic        w_alertZero;
  logic        w_blinkZero;
  logic        w_expire;
  logic        w_blinkToggle;
  logic        w_alertLoad;
  logic [15:0] w_alertLoadVal;
  logic        w_blinkLoad;

  assign w_keyHit      = (i_key_val != 3'd0);
  assign w_anyReq      = (i_req != 3'd0);
  assign w_firstReq    = first_req(i_req);
  assign w_grantReq    = i_req[r_grant];
  assign w_preempt     = w_anyReq && (w_firstReq < r_grant);
  assign w_expire      = i_tick_ms && w_alertZero;
  assign w_blinkToggle = i_tick_ms && w_blinkZero;

  // Decide when the alert/holdoff and blink counters are (re)loaded, mirroring the FSM transitions.
  always_comb begin
    w_alertLoad    = 1'b0;
    w_alertLoadVal = ALERT_LOAD;
    w_blinkLoad    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          w_alertLoad = 1'b1;
          w_blinkLoad = 1'b1;
        end
      end
      ST_ALERT: begin
        if (!w_grantReq || w_keyHit || w_expire) begin
          w_alertLoad    = 1'b1;
          w_alertLoadVal = HOLD_LOAD;
        end else if (w_preempt) begin
          w_alertLoad = 1'b1;
          w_blinkLoad = 1'b1;
        end else if (w_blinkToggle) begin
          w_blinkLoad = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  ms_down_counter #(.WIDTH(16)) u_alert_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_alertLoad),
    .i_load_val (w_alertLoadVal),
    .i_tick     (i_tick_ms),
    .o_zero     (w_alertZero)
  );

  ms_down_counter #(.WIDTH(16)) u_blink_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_blinkLoad),
    .i_load_val (BLINK_LOAD),
    .i_tick     (i_tick_ms),
    .o_zero     (w_blinkZero)
  );

  // Arbitration FSM; a vanished request beats a key, a key beats timeout, timeout beats pre-emption.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_grant <= 2'd0;
      r_buz   <= 1'b0;
      r_ack   <= 3'd0;
    end else begin
      r_ack <= 3'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_state <= ST_ALERT;
            r_busy  <= 1'b1;
            r_grant <= w_firstReq;
            r_buz   <= 1'b1;
          end
        end
        ST_ALERT: begin
          if (!w_grantReq) begin
            r_state <= ST_HOLDOFF;
            r_busy  <= 1'b0;
            r_buz   <= 1'b0;
          end else if (w_keyHit || w_expire) begin
            r_state <= ST_HOLDOFF;
            r_busy  <= 1'b0;
            r_buz   <= 1'b0;
            r_ack   <= 3'b001 << r_grant;
          end else if (w_preempt) begin
            r_grant <= w_firstReq;
            r_buz   <= 1'b1;
          end else if (w_blinkToggle) begin
            r_buz <= ~r_buz;
          end
        end
        ST_HOLDOFF: begin
          if (w_expire) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_buz   <= 1'b0;
        end
      endcase
    end
  end

  assign o_data         = (r_state == ST_ALERT) ? i_req_data[int'(r_grant)*DATA_W +: DATA_W] : i_mode_data;
  assign o_key_val_mode = (r_state == ST_IDLE) ? i_key_val : 3'd0;
  assign o_buz          = r_buz;
  assign o_busy         = r_busy;
  assign o_grant_id     = r_grant;
  assign o_ack          = r_ack;

endmodule

// File: doc/alert_arbiter.md
# alert_arbiter

Shares the single seven-segment display path and the buzzer between the normal mode display and up to three asynchronous alert requesters: timer expiry, clock alarm and hourly chime. It sits between the mode logic (clock/stopwatch/timer and the mode FSM) and the `seg`/buzzer outputs. It grants by fixed priority, with pre-emption, and times out every alert. While an alert is active it takes ownership of the debounced keys, so a dismiss press never reaches the mode logic.

## Interface
Parameters:
- `DATA_W`, 21: display word width, the same as the `seg` data input.
- `ALERT_MS`, 10000: maximum alert duration in ms before auto-dismiss.
- `BLINK_MS`, 500: buzzer on/off half-period in ms.
- `HOLDOFF_MS`, 200: quiet gap after an alert ends.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_ms`  in  1  one-cycle pulse, once per ms.
- `key_val`  in  3  debounced key code, nonzero for exactly one cycle per press (1..4 = S1..S4).
- `mode_data`  in  DATA_W  display word from the currently selected mode.
- `req`  in  3  level alert requests; bit 0 timer expiry (highest priority), bit 1 alarm, bit 2 chime (lowest).
- `req_data`  in  3*DATA_W  display word per requester; requester i uses bits [i*DATA_W +: DATA_W].
- `data`  out  DATA_W  word driven to `seg`.
- `key_val_mode`  out  3  key code forwarded to the mode logic.
- `buz`  out  1  buzzer drive, 1 = sounding.
- `busy`  out  1  high in ALERT.
- `grant_id`  out  2  index of the granted requester; valid while `busy`.
- `ack`  out  3  one-hot, one-cycle pulse when the granted alert is dismissed or times out.

## Operation
The FSM has three states: IDLE, ALERT and HOLDOFF.

- **IDLE**
  - `data = mode_data` and `key_val_mode = key_val`.
  - If any `req` bit is set, grant the lowest-index set bit, load the alert counter with ALERT_MS, set blink phase to on, and go to ALERT.
- **ALERT**
  - `data = req_data[grant_id]`, `buz` = blink phase, `key_val_mode = 0`.
  - Any nonzero `key_val` dismisses the alert: pulse `ack[grant_id]` and go to HOLDOFF. The key is swallowed.
  - The alert counter decrements on `tick_ms`. When it reaches 0: pulse `ack[grant_id]` and go to HOLDOFF.
  - If `req[grant_id]` drops, go to HOLDOFF with no ack.
  - Pre-emption: if a higher-priority `req` is set, switch `grant_id`, reload ALERT_MS and restart the blink phase on. There is no ack to the pre-empted requester; it is re-served later if it is still requesting.
  - The blink counter toggles the phase every BLINK_MS ticks.
- **HOLDOFF**
  - `data = mode_data`, `buz = 0`, `key_val_mode = 0` (keys are swallowed to block double presses).
  - The counter is loaded with HOLDOFF_MS on entry. When it reaches 0, go to IDLE.
  - Requesters must drop `req` within HOLDOFF_MS after `ack`.

Priority when events coincide in ALERT:
- Key press beats timeout and beats pre-emption: exactly one ack, to the current grant, then HOLDOFF.
- Timeout beats pre-emption.
- Drop of `req[grant_id]` together with a key press: no ack.

Arithmetic:
- Counters are 16-bit unsigned, loaded with parameter values; ALERT_MS and HOLDOFF_MS must be ≤ 65535.
- Decrement happens only on `tick_ms` and never wraps below 0.
- The blink counter is a separate counter, 0..BLINK_MS-1.

## Timing
- Reset, applied asynchronously and at any time (including mid-alert):
  - state IDLE, `busy` 0, `grant_id` 0, `buz` 0, `ack` 0, all counters 0.
  - The combinational outputs then give `data = mode_data` and `key_val_mode = key_val`.
- `req` rising in cycle t: `busy`, `grant_id`, `data` and `buz` switch at t+1.
- Dismiss key in cycle t: `ack` is high in cycle t+1 only, coincident with state HOLDOFF. `busy` falls at t+1.
- Timeout: `ack` and HOLDOFF follow one cycle after the `tick_ms` that brings the counter to 0. Alert length is ALERT_MS ticks ±1 cycle.
- `data` and `key_val_mode` are combinational from the registered state. `busy`, `grant_id`, `buz` and `ack` are registered.
- Pass-through in IDLE has zero cycles of latency.

## Structure
- Shared package (`chrono_pkg`):
  - state encoding IDLE/ALERT/HOLDOFF
  - requester index constants REQ_TIMER = 0, REQ_ALARM = 1, REQ_CHIME = 2
  - key code constants S1..S4
  - DATA_W
- One sub-module, `ms_down_counter`: load value, decrement on `tick_ms`, `zero` flag. It is instantiated twice: once for the alert/holdoff counter and once for blink.
- The priority encoder and the FSM are inline.

## Test plan
- **Single alert, timeout:** ALERT_MS = 20, BLINK_MS = 5, `req` = 3'b010.
  - At t+1: `busy` 1, `grant_id` 1, `data = req_data[1]`.
  - `buz` toggles every 5 ticks.
  - After 20 ticks: `ack` = 3'b010 for one cycle, then 0 for HOLDOFF_MS ticks, then IDLE.
- **Key dismiss:** during ALERT, `key_val` = 2 for one cycle.
  - `ack` pulses next cycle.
  - `key_val_mode` stays 0 throughout.
  - A key pressed in HOLDOFF is swallowed; a key pressed in IDLE passes through unchanged.
- **Pre-emption:** chime active (`grant_id` 2), then `req[0]` rises.
  - Next cycle: `grant_id` 0, counter reloaded, no `ack[2]`.
  - After timer ack and holdoff, with `req[2]` still high: chime is re-granted.
- **Simultaneous:** key press and final tick in the same cycle give exactly one ack. Key press and higher-priority `req` in the same cycle give an ack to the current grant, then HOLDOFF.
- **Withdrawal:** `req[1]` drops mid-alert → HOLDOFF, `ack` stays 0.
- **Reset mid-alert:** `rst` pulse → `busy`, `buz` and `ack` are 0 immediately, `data` follows `mode_data`, and an alert is re-granted one cycle after `rst` deasserts if `req` is still high.
